// File: rtl/count_bcd_scan_if.sv
// Display bus between the upstream counter and the BCD scan stage.
// The counter side drives Count; the display stage drives the segment and digit outputs.
interface count_bcd_scan_if;
  logic [3:0] Count;
  logic [6:0] Seg;
  logic [1:0] DigitEn;
  logic       Changed;

  modport master (
    output Count,
    input  Seg,
    input  DigitEn,
    input  Changed
  );

  modport slave (
    input  Count,
    output Seg,
    output DigitEn,
    output Changed
  );
endinterface

// File: rtl/count_bcd_scan.sv
// Two-digit BCD display driver for a 4-bit counter: registers the count, splits it into
// tens/units and time-multiplexes both digits onto one 7-segment bus with registered outputs.
module count_bcd_scan #(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic                 Clk,
  input logic                 Reset,
  count_bcd_scan_if.slave     bus
);

  localparam int unsigned PrescW = $clog2(SCAN_DIV);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);

  typedef enum logic [0:0] {StUnits, StTens} state_e;

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;

  logic [3:0] cnt_q;
  logic       changed_q;
  logic [6:0] seg_q, seg_d;
  logic [1:0] digit_en_q, digit_en_d;

  logic       tens;
  logic [3:0] units;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Count is at most 15, so the tens digit is a single compare.
  assign tens  = (cnt_q >= 4'd10);
  assign units = tens ? (cnt_q - 4'd10) : cnt_q;

  // Scan FSM: state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StUnits;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  // Scan FSM: next state. Each digit dwells for SCAN_DIV cycles.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q + PrescW'(1);
    if (presc_q == PrescMax) begin
      presc_d = '0;
      unique case (state_q)
        StUnits: state_d = StTens;
        StTens:  state_d = StUnits;
        default: state_d = StUnits;
      endcase
    end
  end

  // Scan FSM: outputs for the digit currently selected.
  always_comb begin
    seg_d      = 7'h00;
    digit_en_d = 2'b00;
    unique case (state_q)
      StUnits: begin
        digit_en_d = 2'b01;
        seg_d      = dec(units);
      end
      StTens: begin
        if (tens) begin
          digit_en_d = 2'b10;
          seg_d      = dec(4'd1);
        end else if (!BLANK_LZ) begin
          digit_en_d = 2'b10;
          seg_d      = dec(4'd0);
        end
      end
      default: begin
        digit_en_d = 2'b00;
        seg_d      = 7'h00;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q      <= 4'd0;
      changed_q  <= 1'b0;
      seg_q      <= 7'h00;
      digit_en_q <= 2'b00;
    end else begin
      cnt_q      <= bus.Count;
      changed_q  <= (bus.Count != cnt_q);
      seg_q      <= seg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign bus.Seg     = seg_q;
  assign bus.DigitEn = digit_en_q;
  assign bus.Changed = changed_q;

endmodule
